// File: rtl/ifu_iccm_mem_ctl_pkg.sv
// -----------------------------------------------------------------------------
// ifu_iccm_mem_ctl_pkg
// Shared types and encodings for the ICCM array controller.
//   init_state_e   : init sequencer states (IDLE, INIT)
//   ICCM_WR_WORD   : wr_size code for a single-word write
//   ICCM_WR_DWORD  : wr_size code for a double-word write
// -----------------------------------------------------------------------------
package ifu_iccm_mem_ctl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } init_state_e;

   localparam logic [1:0] ICCM_WR_WORD  = 2'b10;
   localparam logic [1:0] ICCM_WR_DWORD = 2'b11;

endpackage

// File: rtl/ifu_iccm_mem_ctl_if.sv
// -----------------------------------------------------------------------------
// ifu_iccm_mem_ctl_if
// Request/response bundle between the IFU fetch/DMA side and the ICCM controller.
//   Requester -> controller : rd_req, wr_req, addr[AW-1:2], wr_size, wr_data, init_req
//   Controller -> requester : ready, rd_valid, rd_data, init_busy, init_done
// Modports: master (requester side), slave (controller side).
// -----------------------------------------------------------------------------
interface ifu_iccm_mem_ctl_if #(
   parameter int AW       = 14,
   parameter int DATA_W   = 39,
   parameter int RD_WORDS = 4
);

   logic                         rd_req;
   logic                         wr_req;
   logic [AW-1:2]                addr;
   logic [1:0]                   wr_size;
   logic [2*DATA_W-1:0]          wr_data;
   logic                         ready;
   logic                         rd_valid;
   logic [RD_WORDS*DATA_W-1:0]   rd_data;
   logic                         init_req;
   logic                         init_busy;
   logic                         init_done;

   modport master (
      output rd_req, wr_req, addr, wr_size, wr_data, init_req,
      input  ready, rd_valid, rd_data, init_busy, init_done
   );

   modport slave (
      input  rd_req, wr_req, addr, wr_size, wr_data, init_req,
      output ready, rd_valid, rd_data, init_busy, init_done
   );

endinterface

// File: rtl/ifu_iccm_mem_ctl_bank_ram.sv
// -----------------------------------------------------------------------------
// iccm_bank_ram
// Behavioural single-port DEPTH x DATA_W bank: synchronous write, registered
// read, no reset. dout only updates on a read (en & ~we), so it holds the last
// read word across writes and idle cycles.
//   clk  : clock
//   en   : bank enable (access this cycle)
//   we   : write enable (qualified by en)
//   idx  : row index
//   din  : write data
//   dout : registered read data
// -----------------------------------------------------------------------------
module iccm_bank_ram #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 39,
   localparam int IDX_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [IDX_BITS-1:0] idx,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Array write or registered read; nothing happens without en.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[idx] <= din;
         end else begin
            dout <= mem_r[idx];
         end
      end
   end

endmodule

// File: rtl/ifu_iccm_mem_ctl.sv
// -----------------------------------------------------------------------------
// ifu_iccm_mem_ctl
// Parametrised ICCM array controller. Reads return RD_WORDS consecutive words
// starting at any word address (wrapping across banks and the top of memory);
// writes store one or two words. An init sequencer fills every location with
// INIT_VAL after reset (INIT_ON_RESET) or on init_req.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ifu_iccm_mem_ctl_if.slave (request/response bundle)
// -----------------------------------------------------------------------------
`ifndef RV_ICCM_DATA_CELL
`define RV_ICCM_DATA_CELL iccm_bank_ram
`endif

module ifu_iccm_mem_ctl
   import ifu_iccm_mem_ctl_pkg::*;
#(
   parameter int               NUM_BANKS     = 4,
   parameter int               DATA_W        = 39,
   parameter int               DEPTH         = 1024,
   parameter int               RD_WORDS      = 4,
   parameter int               INIT_ON_RESET = 1,
   parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
   input  logic               clk,
   input  logic               rst,
   ifu_iccm_mem_ctl_if.slave  bus
);

   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int IDX_BITS  = $clog2(DEPTH);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

   init_state_e               state_r;
   logic [IDX_BITS-1:0]       cnt_r;
   logic                      ready_r;
   logic                      init_busy_r;
   logic                      init_done_r;
   logic                      rd_valid_r;
   logic                      rd_seen_r;
   logic [BANK_BITS-1:0]      rd_bank_r;

   logic [BANK_BITS-1:0]      bank_s;
   logic [IDX_BITS-1:0]       idx_s;
   logic                      wr_acc_s;
   logic                      rd_acc_s;
   logic                      wr_word_s;
   logic                      wr_dword_s;
   logic [RD_WORDS*DATA_W-1:0] rd_data_s;
   logic [DATA_W-1:0]         dout_s [NUM_BANKS];

   assign bank_s     = bus.addr[BANK_BITS+1:2];
   assign idx_s      = bus.addr[BANK_BITS+2 +: IDX_BITS];
   // A simultaneous read loses to the write; the requester keeps rd_req up.
   assign wr_acc_s   = ready_r & bus.wr_req;
   assign rd_acc_s   = ready_r & bus.rd_req & ~bus.wr_req;
   assign wr_word_s  = (bus.wr_size == ICCM_WR_WORD);
   assign wr_dword_s = (bus.wr_size == ICCM_WR_DWORD);

   // Init sequencer with registered ready/busy/done outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= (INIT_ON_RESET != 0) ? INIT : IDLE;
         ready_r     <= (INIT_ON_RESET == 0);
         init_busy_r <= (INIT_ON_RESET != 0);
         init_done_r <= 1'b0;
         cnt_r       <= '0;
      end else begin
         init_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.init_req) begin
                  state_r     <= INIT;
                  ready_r     <= 1'b0;
                  init_busy_r <= 1'b1;
                  cnt_r       <= '0;
               end
            end
            INIT: begin
               if (cnt_r == LAST_IDX) begin
                  state_r     <= IDLE;
                  ready_r     <= 1'b1;
                  init_busy_r <= 1'b0;
                  init_done_r <= 1'b1;
                  cnt_r       <= '0;
               end else begin
                  cnt_r <= cnt_r + IDX_BITS'(1);
               end
            end
            default: begin
               state_r     <= IDLE;
               ready_r     <= 1'b1;
               init_busy_r <= 1'b0;
               cnt_r       <= '0;
            end
         endcase
      end
   end

   // Read response tracking: valid pulse, start bank of the read, first-read flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_r <= 1'b0;
         rd_seen_r  <= 1'b0;
         rd_bank_r  <= '0;
      end else begin
         rd_valid_r <= rd_acc_s;
         if (rd_acc_s) begin
            rd_seen_r <= 1'b1;
            rd_bank_r <= bank_s;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic [BANK_BITS-1:0] BANK_ID = BANK_BITS'(b);

      logic [BANK_BITS-1:0] ofs_s;
      logic [IDX_BITS-1:0]  row_s;
      logic                 en_s;
      logic                 we_s;
      logic [IDX_BITS-1:0]  ram_idx_s;
      logic [DATA_W-1:0]    din_s;

      // Per-bank enable/row/data: banks below the start bank hold words past
      // the row boundary and use idx+1 (wrapping modulo DEPTH).
      always_comb begin
         ofs_s     = BANK_ID - bank_s;
         row_s     = idx_s + ((BANK_ID < bank_s) ? IDX_BITS'(1) : IDX_BITS'(0));
         en_s      = 1'b0;
         we_s      = 1'b0;
         ram_idx_s = row_s;
         din_s     = (ofs_s == '0) ? bus.wr_data[DATA_W-1:0]
                                   : bus.wr_data[2*DATA_W-1:DATA_W];
         if (state_r == INIT) begin
            en_s      = 1'b1;
            we_s      = 1'b1;
            ram_idx_s = cnt_r;
            din_s     = INIT_VAL;
         end else if (wr_acc_s) begin
            if (wr_dword_s) begin
               en_s = (ofs_s <= BANK_BITS'(1));
               we_s = (ofs_s <= BANK_BITS'(1));
            end else if (wr_word_s) begin
               en_s = (ofs_s == '0);
               we_s = (ofs_s == '0);
            end else begin
               en_s = 1'b0;
               we_s = 1'b0;
            end
         end else if (rd_acc_s) begin
            en_s = ({1'b0, ofs_s} < (BANK_BITS+1)'(RD_WORDS));
            we_s = 1'b0;
         end else begin
            en_s = 1'b0;
            we_s = 1'b0;
         end
      end

      `RV_ICCM_DATA_CELL #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_ram (
         .clk  (clk),
         .en   (en_s),
         .we   (we_s),
         .idx  (ram_idx_s),
         .din  (din_s),
         .dout (dout_s[b])
      );
   end

   // Rotate the registered bank outputs so word k comes from bank start+k.
   always_comb begin
      rd_data_s = '0;
      for (int k = 0; k < RD_WORDS; k++) begin
         if (rd_seen_r) begin
            rd_data_s[k*DATA_W +: DATA_W] = dout_s[rd_bank_r + BANK_BITS'(k)];
         end else begin
            rd_data_s[k*DATA_W +: DATA_W] = '0;
         end
      end
   end

   assign bus.ready     = ready_r;
   assign bus.init_busy = init_busy_r;
   assign bus.init_done = init_done_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_data   = rd_data_s;

endmodule

// File: tb/tb_ifu_iccm_mem_ctl.sv
module tb_ifu_iccm_mem_ctl;

   localparam int NB    = 4;
   localparam int DW    = 39;
   localparam int DEP   = 16;
   localparam int RW    = 4;
   localparam int AW    = 8;
   localparam int NWORD = NB * DEP;
   localparam logic [DW-1:0] IVAL = 39'h7F_FFFF_FFFF;
   localparam int RDW   = RW * DW;

   logic clk;
   logic rst;

   ifu_iccm_mem_ctl_if #(.AW(AW), .DATA_W(DW), .RD_WORDS(RW)) bus ();

   ifu_iccm_mem_ctl #(
      .NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DEP), .RD_WORDS(RW),
      .INIT_ON_RESET(1), .INIT_VAL(IVAL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [DW-1:0]  mem_m [NWORD];
   logic [RDW-1:0] sb_q [$];
   logic [RDW-1:0] last_exp = '0;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [RDW-1:0] obs, input logic [RDW-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_fill();
      for (int i = 0; i < NWORD; i++) mem_m[i] = IVAL;
   endtask

   task automatic do_write(input logic [5:0] wa, input logic [1:0] sz,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic [5:0] wa1;
      wa1 = wa + 6'd1;
      bus.wr_req  = 1'b1;
      bus.addr    = wa;
      bus.wr_size = sz;
      bus.wr_data = {d1, d0};
      cycle();
      bus.wr_req = 1'b0;
      chk("write no rd_valid", RDW'(bus.rd_valid), RDW'(1'b0));
      if (sz == 2'b10) begin
         mem_m[wa] = d0;
      end else if (sz == 2'b11) begin
         mem_m[wa]  = d0;
         mem_m[wa1] = d1;
      end
   endtask

   task automatic push_exp(input logic [5:0] wa);
      logic [RDW-1:0] e;
      logic [5:0] a;
      for (int k = 0; k < RW; k++) begin
         a = wa + 6'(k);
         e[k*DW +: DW] = mem_m[a];
      end
      sb_q.push_back(e);
   endtask

   task automatic check_resp(input string tag);
      chk({tag, " valid"}, RDW'(bus.rd_valid), RDW'(1'b1));
      if (sb_q.size() > 0) begin
         last_exp = sb_q.pop_front();
         chk({tag, " data"}, bus.rd_data, last_exp);
      end else begin
         total_cnt++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end
      cycle();
      chk({tag, " pulse"}, RDW'(bus.rd_valid), RDW'(1'b0));
      chk({tag, " hold"}, bus.rd_data, last_exp);
   endtask

   task automatic do_read(input logic [5:0] wa, input string tag);
      bus.rd_req = 1'b1;
      bus.addr   = wa;
      push_exp(wa);
      cycle();
      bus.rd_req = 1'b0;
      check_resp(tag);
   endtask

   // Runs one init window from the current INIT state, holding rd_req (must be
   // refused) and pulsing init_req mid-sequence (must be ignored).
   task automatic run_init(input string tag);
      int n;
      int dc;
      n  = 0;
      dc = 0;
      bus.rd_req = 1'b1;
      bus.addr   = 6'd0;
      do begin
         cycle();
         n++;
         bus.init_req = (n == 4);
         if (bus.init_done) dc++;
         if (bus.init_busy) chk({tag, " no accept in init"}, RDW'(bus.rd_valid), RDW'(1'b0));
      end while (bus.init_busy && n < 100);
      bus.rd_req   = 1'b0;
      bus.init_req = 1'b0;
      chk({tag, " busy cycles"}, RDW'(n), RDW'(DEP));
      chk({tag, " ready after"}, RDW'(bus.ready), RDW'(1'b1));
      chk({tag, " done at end"}, RDW'(bus.init_done), RDW'(1'b1));
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (bus.init_done) dc++;
      end
      chk({tag, " done pulses"}, RDW'(dc), RDW'(1));
      chk({tag, " busy stays low"}, RDW'(bus.init_busy), RDW'(1'b0));
      model_fill();
   endtask

   initial begin
      rst          = 1'b1;
      bus.rd_req   = 1'b0;
      bus.wr_req   = 1'b0;
      bus.addr     = '0;
      bus.wr_size  = 2'b00;
      bus.wr_data  = '0;
      bus.init_req = 1'b0;
      cycle();
      cycle();
      chk("reset ready", RDW'(bus.ready), RDW'(1'b0));
      chk("reset busy", RDW'(bus.init_busy), RDW'(1'b1));
      chk("reset rd_valid", RDW'(bus.rd_valid), RDW'(1'b0));
      chk("reset rd_data", bus.rd_data, RDW'(0));
      chk("reset done", RDW'(bus.init_done), RDW'(1'b0));

      // 1: init after reset, then read back the init value
      rst = 1'b0;
      run_init("init1");
      do_read(6'd0, "rd init");

      // 2: word write then read one below, next cycle
      do_write(6'd5, 2'b10, 39'h1_2345_6789, 39'h0);
      do_read(6'd4, "rd wa4");

      // 3: double write across bank3 -> bank0 row+1
      do_write(6'd3, 2'b11, 39'h1_AAAA, 39'h2_BBBB);
      do_read(6'd3, "rd wa3");
      do_read(6'd4, "rd wa4b");

      // 4: top-of-memory wrap
      do_write(6'd63, 2'b10, 39'h63_6363, 39'h0);
      do_write(6'd0,  2'b10, 39'h00_0A0A, 39'h0);
      do_write(6'd1,  2'b10, 39'h11_1B1B, 39'h0);
      do_write(6'd2,  2'b10, 39'h22_2C2C, 39'h0);
      do_read(6'd63, "rd wrap");
      do_write(6'd63, 2'b11, 39'h4_0F0F, 39'h5_E0E0);
      do_read(6'd62, "rd dwrap");

      // 5: read and write together: write wins, read completes later
      bus.rd_req  = 1'b1;
      bus.wr_req  = 1'b1;
      bus.addr    = 6'd10;
      bus.wr_size = 2'b10;
      bus.wr_data = {39'h0, 39'h55};
      cycle();
      mem_m[10] = 39'h55;
      bus.wr_req = 1'b0;
      chk("rw collide no valid", RDW'(bus.rd_valid), RDW'(1'b0));
      push_exp(6'd10);
      cycle();
      bus.rd_req = 1'b0;
      check_resp("rw retry");

      // non-word size codes are consumed without writing
      do_write(6'd10, 2'b01, 39'h7_7777, 39'h6_6666);
      do_write(6'd11, 2'b00, 39'h7_7777, 39'h6_6666);
      do_read(6'd10, "rd bad size");

      // 6: init by request, reset at counter 7, full restart
      bus.init_req = 1'b1;
      cycle();
      bus.init_req = 1'b0;
      chk("init_req busy", RDW'(bus.init_busy), RDW'(1'b1));
      for (int i = 0; i < 7; i++) cycle();
      chk("mid init busy", RDW'(bus.init_busy), RDW'(1'b1));
      rst = 1'b1;
      #1;
      chk("rst2 ready", RDW'(bus.ready), RDW'(1'b0));
      chk("rst2 busy", RDW'(bus.init_busy), RDW'(1'b1));
      chk("rst2 rd_data", bus.rd_data, RDW'(0));
      cycle();
      cycle();
      rst = 1'b0;
      run_init("init2");
      do_read(6'd10, "rd after reinit");
      do_read(6'd63, "rd top after reinit");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ifu_iccm_mem_ctl.md
Name: ifu_iccm_mem_ctl

Overview:
- Parametrised ICCM array controller, next generation of the fixed 4-bank ICCM memory.
- Configurable bank count, word width, depth and read width.
- Unaligned multi-word reads that wrap across banks and across the top of memory.
- Single/double-word writes with a request/ready handshake, plus a hardware init sequencer that fills every location after reset or on request.
- Sits between IFU fetch/DMA access logic and the per-bank single-port RAM macros.

Parameters:
NUM_BANKS, 4, number of word-wide banks; power of 2, >=2
DATA_W, 39, bits per word (32 data + 7 ECC, ECC generated outside)
DEPTH, 1024, entries per bank; power of 2
RD_WORDS, 4, consecutive words returned per read; 2 <= RD_WORDS <= NUM_BANKS
INIT_ON_RESET, 1, 1 = run the init sequence automatically on reset release
INIT_VAL, 0, DATA_W-bit value written by the init sequence
(local) BANK_BITS = log2(NUM_BANKS); IDX_BITS = log2(DEPTH); AW = BANK_BITS+IDX_BITS+2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_req  in  1  read request
wr_req  in  1  write request
addr  in  AW-2 [AW-1:2]  word address
wr_size  in  2  2'b10 = word, 2'b11 = double word; other codes = no write
wr_data  in  2*DATA_W  word0 in [DATA_W-1:0], word1 in the upper half
ready  out  1  controller can accept a request this cycle
rd_valid  out  1  rd_data valid (1-cycle pulse)
rd_data  out  RD_WORDS*DATA_W  word k (addr+k) at [k*DATA_W +: DATA_W]
init_req  in  1  start the init sequence
init_busy  out  1  init sequence in progress
init_done  out  1  1-cycle pulse on init completion

Behaviour:
- Address decode:
  - wa = addr; bank = wa[BANK_BITS-1:0]; idx = wa >> BANK_BITS.
  - Word wa+k uses bank (bank+k) mod NUM_BANKS and idx+carry.
  - The index wraps modulo DEPTH, so the top address wraps to word 0.
- Handshake:
  - accept = ready & (rd_req | wr_req).
  - If rd_req and wr_req are both set: the write is performed, the read is not accepted and rd_valid does not pulse. The requester holds rd_req; the read completes on a later cycle.
  - Accepted write with wr_size = 2'b11 writes wa and wa+1. The pair may span banks NUM_BANKS-1 -> 0 with idx+1, and wraps at the top of memory.
  - Accepted write with any other non-word code (not 2'b10/2'b11) is consumed and no RAM is written.
- Read latency:
  - rd_valid and rd_data are asserted the cycle after the read is accepted.
  - rd_data is registered and holds its value until the next accepted read.
- Read after write: a read accepted in the cycle after a write returns the new data.
- Bank enables: only the banks touched by the current access (or by init) are enabled. Idle banks get no enable, for clock-gating downstream.
- Init FSM, states IDLE and INIT:
  - Reset: state = INIT if INIT_ON_RESET, else IDLE; counter = 0.
  - IDLE -> INIT on init_req.
  - INIT: all banks write INIT_VAL at index counter in parallel; counter increments each cycle.
  - At counter == DEPTH-1: write, then go to IDLE, pulse init_done in that transition cycle, clear counter. INIT lasts exactly DEPTH cycles.
  - init_req during INIT is ignored.
  - ready = (state == IDLE); init_busy = (state == INIT).
  - Requests during INIT are not accepted.
- Reset values: rd_valid 0, rd_data 0, init_done 0, counter 0; ready and init_busy follow the reset state.
- Reset mid-init aborts the sequence; init restarts from index 0 if INIT_ON_RESET.
- RAM contents are never reset.

Decomposition:
- Shared package (swerv_types or an iccm_pkg) holds:
  - enum typedef for the init state {IDLE, INIT};
  - wr_size encodings ICCM_WR_WORD = 2'b10 and ICCM_WR_DWORD = 2'b11.
- One sub-module, iccm_bank_ram: single-port, DEPTH x DATA_W, synchronous write, registered read, enable + write-enable, no reset.
- It is instantiated NUM_BANKS times in a generate loop; the macro swap point is the `RV_ICCM_DATA_CELL instance.

Test Plan:
1. Config NUM_BANKS=4, DEPTH=16, INIT_ON_RESET=1, INIT_VAL=0x7F_FFFF_FFFF → release rst: init_busy high and ready low for 16 cycles, init_done pulses on cycle 16; read wa=0 then returns 4 words of 0x7F_FFFF_FFFF.
2. Word write wa=5 with 0x1_2345_6789, then read wa=4 next cycle → rd_valid 1 cycle after accept; word1 = 0x1_2345_6789, words 0/2/3 = init value.
3. Double write wa=3 with {0x2_BBBB, 0x1_AAAA} (bank3 idx0, bank0 idx1) → read wa=3 gives word0 0x1_AAAA, word1 0x2_BBBB; read wa=4 gives word0 0x2_BBBB.
4. Write distinct values at wa=63,0,1,2, then read wa=63 → rd_data words = values of wa 63,0,1,2 (top-of-memory wrap).
5. rd_req and wr_req asserted together at wa=10 with data 0x55 → no rd_valid that cycle; read accepted next cycle returns 0x55 one cycle later.
6. Assert rst while the init counter = 7, release → init restarts with the full 16-cycle busy window and a single init_done pulse; init_req pulsed during INIT causes no extra cycles.
